// File: rtl/hazard_forward_ctrl_pkg.sv
// rtl/hazard_forward_ctrl_pkg.sv - shared encodings for the hazard/forwarding controller
package hazard_forward_ctrl_pkg;

    // EX operand mux select encodings
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEM     = 2'b01;
    localparam logic [1:0] FWD_WB      = 2'b10;

    // Hard-wired zero register: never a forwarding or stall source
    localparam int unsigned X0 = 0;

    // Hazard FSM states
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STALL   = 2'd1,
        S_MEMWAIT = 2'd2
    } state_e;

    // MEM wins over WB, but a load in MEM has no data yet so it falls through to WB
    function automatic logic [1:0] fwd_pick(input logic mem_hit,
                                            input logic mem_is_load,
                                            input logic wb_hit);
        if (mem_hit && !mem_is_load) begin
            return FWD_MEM;
        end else if (wb_hit) begin
            return FWD_WB;
        end else begin
            return FWD_REGFILE;
        end
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_src_match.sv
// rtl/hazard_forward_ctrl_src_match.sv - one source register vs. one producer destination
module hazard_forward_ctrl_src_match
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] rs_i,
    input  logic          rs_valid_i,
    input  logic [AW-1:0] rd_i,
    input  logic          reg_write_i,
    output logic          hit_o
);

    // A hit needs a used operand, a writing producer, equal regs and a non-x0 target
    assign hit_o = rs_valid_i & reg_write_i & (rs_i == rd_i) & (rd_i != AW'(X0));

endmodule

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - load-use stall, memory freeze and operand forwarding control
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int NUM_SRC      = 2,
    parameter int AW           = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_SRC*AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]    id_rs_valid,
    input  logic [NUM_SRC*AW-1:0] ex_rs,
    input  logic [NUM_SRC-1:0]    ex_rs_valid,
    input  logic [AW-1:0]         ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_is_load,
    input  logic [AW-1:0]         mem_rd,
    input  logic                  mem_reg_write,
    input  logic                  mem_is_load,
    input  logic [AW-1:0]         wb_rd,
    input  logic                  wb_reg_write,
    input  logic                  mem_busy,
    input  logic                  flush,
    output logic [2*NUM_SRC-1:0]  fwd_sel,
    output logic                  stall_pc,
    output logic                  stall_ifid,
    output logic                  bubble_idex,
    output logic                  freeze_all,
    output logic [CNT_W-1:0]      stall_cycles
);

    // Remaining bubbles after the first one, which is issued from IDLE
    localparam logic [2:0] BCNT_INIT = 3'(LOAD_BUBBLES - 1);
    localparam bit         MULTI_BUBBLE = (LOAD_BUBBLES > 1);

    logic [NUM_SRC-1:0] id_hit;
    logic [NUM_SRC-1:0] mem_hit;
    logic [NUM_SRC-1:0] wb_hit;
    logic               luh;

    state_e             state_q, state_d;
    logic [2:0]         bcnt_q, bcnt_d;
    logic [CNT_W-1:0]   stall_cycles_q;

    // Per-source comparators: ID vs EX (load-use), EX vs MEM and EX vs WB (forwarding)
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        hazard_forward_ctrl_src_match #(.AW(AW)) u_id_ex (
            .rs_i        (id_rs[k*AW +: AW]),
            .rs_valid_i  (id_rs_valid[k]),
            .rd_i        (ex_rd),
            .reg_write_i (ex_reg_write),
            .hit_o       (id_hit[k])
        );
        hazard_forward_ctrl_src_match #(.AW(AW)) u_ex_mem (
            .rs_i        (ex_rs[k*AW +: AW]),
            .rs_valid_i  (ex_rs_valid[k]),
            .rd_i        (mem_rd),
            .reg_write_i (mem_reg_write),
            .hit_o       (mem_hit[k])
        );
        hazard_forward_ctrl_src_match #(.AW(AW)) u_ex_wb (
            .rs_i        (ex_rs[k*AW +: AW]),
            .rs_valid_i  (ex_rs_valid[k]),
            .rd_i        (wb_rd),
            .reg_write_i (wb_reg_write),
            .hit_o       (wb_hit[k])
        );
    end

    assign luh = ex_is_load & (|id_hit);

    // Operand forwarding selects, forced to regfile while in reset
    always_comb begin
        fwd_sel = '0;
        if (reset) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                fwd_sel[2*k +: 2] = fwd_pick(mem_hit[k], mem_is_load, wb_hit[k]);
            end
        end
    end

    // State, bubble counter and saturating stall statistics
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            bcnt_q         <= 3'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            if (stall_pc && (stall_cycles_q != {CNT_W{1'b1}})) begin
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            end
        end
    end

    // Next-state: flush beats memory wait, which beats load-use
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            S_STALL: begin
                if (flush) begin
                    state_d = S_IDLE;
                    bcnt_d  = 3'd0;
                end else if (!mem_busy) begin
                    if (bcnt_q <= 3'd1) begin
                        state_d = S_IDLE;
                        bcnt_d  = 3'd0;
                    end else begin
                        bcnt_d = bcnt_q - 3'd1;
                    end
                end
            end
            S_MEMWAIT: begin
                // Flush is held by the branch unit until memory releases
                if (!mem_busy) begin
                    state_d = S_IDLE;
                    if (!flush && luh && MULTI_BUBBLE) begin
                        state_d = S_STALL;
                        bcnt_d  = BCNT_INIT;
                    end
                end
            end
            default: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (mem_busy) begin
                    state_d = S_MEMWAIT;
                end else if (luh && MULTI_BUBBLE) begin
                    state_d = S_STALL;
                    bcnt_d  = BCNT_INIT;
                end
            end
        endcase
    end

    // Pipeline control outputs; bubble and freeze are mutually exclusive by construction
    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        bubble_idex = 1'b0;
        freeze_all  = 1'b0;
        if (reset) begin
            case (state_q)
                S_STALL: begin
                    if (!flush) begin
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                        if (mem_busy) begin
                            freeze_all = 1'b1;
                        end else begin
                            bubble_idex = 1'b1;
                        end
                    end
                end
                S_MEMWAIT: begin
                    if (mem_busy) begin
                        freeze_all = 1'b1;
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                    end else if (!flush && luh) begin
                        stall_pc    = 1'b1;
                        stall_ifid  = 1'b1;
                        bubble_idex = 1'b1;
                    end
                end
                default: begin
                    if (!flush) begin
                        if (mem_busy) begin
                            freeze_all = 1'b1;
                        end else if (luh) begin
                            stall_pc    = 1'b1;
                            stall_ifid  = 1'b1;
                            bubble_idex = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - directed self-checking bench for hazard_forward_ctrl
module tb_hazard_forward_ctrl;

    localparam int NS = 2;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [NS*AW-1:0]  id_rs, ex_rs;
    logic [NS-1:0]     id_rs_valid, ex_rs_valid;
    logic [AW-1:0]     ex_rd, mem_rd, wb_rd;
    logic              ex_reg_write, ex_is_load, mem_reg_write, mem_is_load;
    logic              wb_reg_write, mem_busy, flush;

    logic [2*NS-1:0]   fwd_sel1, fwd_sel3;
    logic              stall_pc1, stall_ifid1, bubble1, freeze1;
    logic              stall_pc3, stall_ifid3, bubble3, freeze3;
    logic [1:0]        cnt1;
    logic [15:0]       cnt3;
    logic [3:0]        sts1, sts3;

    int n_tests = 0;
    int n_fail  = 0;

    assign sts1 = {stall_pc1, stall_ifid1, bubble1, freeze1};
    assign sts3 = {stall_pc3, stall_ifid3, bubble3, freeze3};

    hazard_forward_ctrl #(.NUM_SRC(NS), .AW(AW), .LOAD_BUBBLES(1), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rs_valid(id_rs_valid),
        .ex_rs(ex_rs), .ex_rs_valid(ex_rs_valid), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .mem_busy(mem_busy), .flush(flush),
        .fwd_sel(fwd_sel1), .stall_pc(stall_pc1), .stall_ifid(stall_ifid1),
        .bubble_idex(bubble1), .freeze_all(freeze1), .stall_cycles(cnt1)
    );

    hazard_forward_ctrl #(.NUM_SRC(NS), .AW(AW), .LOAD_BUBBLES(3), .CNT_W(16)) dut3 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rs_valid(id_rs_valid),
        .ex_rs(ex_rs), .ex_rs_valid(ex_rs_valid), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .mem_busy(mem_busy), .flush(flush),
        .fwd_sel(fwd_sel3), .stall_pc(stall_pc3), .stall_ifid(stall_ifid3),
        .bubble_idex(bubble3), .freeze_all(freeze3), .stall_cycles(cnt3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rs_valid = '0; ex_rs = '0; ex_rs_valid = '0;
        ex_rd = '0; ex_reg_write = 1'b0; ex_is_load = 1'b0;
        mem_rd = '0; mem_reg_write = 1'b0; mem_is_load = 1'b0;
        wb_rd = '0; wb_reg_write = 1'b0; mem_busy = 1'b0; flush = 1'b0;
    endtask

    // Load to x7 in EX, instruction in ID reads x7 on source 1
    task automatic set_luh();
        ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd7;
        id_rs = {5'd7, 5'd3}; id_rs_valid = 2'b10;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        clear_inputs();
        tick(); tick();

        // Outputs held low in reset even with hazard and forwarding conditions present
        set_luh();
        ex_rs = {5'd0, 5'd5}; ex_rs_valid = 2'b01; mem_rd = 5'd5; mem_reg_write = 1'b1;
        #1;
        check("rst_sts1", 32'(sts1), 32'h0);
        check("rst_sts3", 32'(sts3), 32'h0);
        check("rst_fwd", 32'(fwd_sel1), 32'h0);
        check("rst_cnt3", 32'(cnt3), 32'h0);

        tick();
        reset = 1'b1;
        clear_inputs();

        // Forwarding priority on source 0
        ex_rs = {5'd0, 5'd5}; ex_rs_valid = 2'b01;
        mem_rd = 5'd5; mem_reg_write = 1'b1; wb_rd = 5'd5; wb_reg_write = 1'b1;
        #1; check("fwd_mem_prio", 32'(fwd_sel1), 32'h1);
        mem_reg_write = 1'b0;
        #1; check("fwd_wb", 32'(fwd_sel1), 32'h2);
        ex_rs = '0; mem_rd = '0; wb_rd = '0; mem_reg_write = 1'b1;
        #1; check("fwd_x0", 32'(fwd_sel1), 32'h0);
        // Source 1: load in MEM falls through to WB; unused source never forwards
        ex_rs = {5'd9, 5'd0}; ex_rs_valid = 2'b10;
        mem_rd = 5'd9; mem_is_load = 1'b1; wb_rd = 5'd9;
        #1; check("fwd_ld_fall_wb", 32'(fwd_sel3), 32'h8);
        ex_rs_valid = 2'b00;
        #1; check("fwd_invalid", 32'(fwd_sel3), 32'h0);

        // Load-use: one bubble on dut1, three on dut3
        tick();
        clear_inputs();
        set_luh();
        #1;
        check("lu1_c0", 32'(sts1), 32'hE);
        check("lu3_c0", 32'(sts3), 32'hE);
        tick();
        clear_inputs();
        mem_rd = 5'd7; mem_reg_write = 1'b1; mem_is_load = 1'b1;
        ex_rs = {5'd0, 5'd7}; ex_rs_valid = 2'b01;
        #1;
        check("lu1_c1", 32'(sts1), 32'h0);
        check("lu1_fwd_ld", 32'(fwd_sel1), 32'h0);
        check("lu3_c1", 32'(sts3), 32'hE);
        tick();
        mem_rd = '0; mem_reg_write = 1'b0; mem_is_load = 1'b0;
        wb_rd = 5'd7; wb_reg_write = 1'b1;
        #1;
        check("lu1_fwd_wb", 32'(fwd_sel1), 32'h2);
        check("lu3_c2", 32'(sts3), 32'hE);
        tick();
        clear_inputs();
        #1;
        check("lu3_c3", 32'(sts3), 32'h0);
        check("lu1_cnt", 32'(cnt1), 32'h1);
        check("lu3_cnt", 32'(cnt3), 32'h3);

        // Memory wait in the second stall cycle of dut3, counters cleared first
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_luh();
        #1;
        check("fz_c0_3", 32'(sts3), 32'hE);
        check("fz_c0_1", 32'(sts1), 32'hE);
        tick();
        clear_inputs();
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("fz_busy3_%0d", i), 32'(sts3), 32'hD);
            check($sformatf("fz_busy1_%0d", i), 32'(sts1), (i == 0) ? 32'h1 : 32'hD);
            tick();
        end
        mem_busy = 1'b0;
        #1;
        check("fz_bub1_3", 32'(sts3), 32'hE);
        check("fz_rel_1", 32'(sts1), 32'h0);
        tick();
        #1; check("fz_bub2_3", 32'(sts3), 32'hE);
        tick();
        #1;
        check("fz_done_3", 32'(sts3), 32'h0);
        check("fz_cnt3", 32'(cnt3), 32'h7);
        check("fz_cnt1_sat", 32'(cnt1), 32'h3);

        // Flush alongside load-use: no stall and FSM stays idle
        set_luh();
        flush = 1'b1;
        #1;
        check("fl_luh_1", 32'(sts1), 32'h0);
        check("fl_luh_3", 32'(sts3), 32'h0);
        tick();
        clear_inputs();
        #1; check("fl_after_3", 32'(sts3), 32'h0);
        // Flush beats mem_busy: next cycle still looks like IDLE entering a wait
        mem_busy = 1'b1; flush = 1'b1;
        #1; check("fl_busy_3", 32'(sts3), 32'h0);
        tick();
        flush = 1'b0;
        #1; check("fl_busy_next_3", 32'(sts3), 32'h1);
        tick();
        mem_busy = 1'b0;
        tick();
        // Flush inside STALL cancels the remaining bubbles
        set_luh();
        #1; check("fl_st_c0", 32'(sts3), 32'hE);
        tick();
        clear_inputs();
        flush = 1'b1;
        #1; check("fl_st_c1", 32'(sts3), 32'h0);
        tick();
        flush = 1'b0;
        #1; check("fl_st_c2", 32'(sts3), 32'h0);

        // Reset pulse mid-stall
        set_luh();
        #1; check("rs_st_c0", 32'(sts3), 32'hE);
        tick();
        reset = 1'b0;
        #1;
        check("rs_st_out3", 32'(sts3), 32'h0);
        check("rs_st_out1", 32'(sts1), 32'h0);
        tick();
        reset = 1'b1;
        clear_inputs();
        #1;
        check("rs_idle3", 32'(sts3), 32'h0);
        check("rs_cnt3", 32'(cnt3), 32'h0);
        check("rs_cnt1", 32'(cnt1), 32'h0);

        // x0 load never stalls; unused sources never stall
        ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = '0;
        id_rs = '0; id_rs_valid = 2'b11;
        #1;
        check("x0_sts3", 32'(sts3), 32'h0);
        check("x0_sts1", 32'(sts1), 32'h0);
        ex_rd = 5'd7; id_rs = {5'd7, 5'd7}; id_rs_valid = 2'b00;
        #1; check("novalid_sts3", 32'(sts3), 32'h0);
        ex_reg_write = 1'b0; id_rs_valid = 2'b11;
        #1; check("nowrite_sts3", 32'(sts3), 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
